// File: rtl/sub_pkg.sv
// Shared types and defaults for the multi-cycle serial subtractor.
package sub_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // The chunk index counter must be at least one bit wide, even when there is only one chunk.
  function automatic int idx_bits(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit subtract with borrow: {Bout, D} = A - B - Bin.
module chunk_subtractor
  import sub_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Bin,
  output logic [CHUNK-1:0] D,
  output logic             Bout
);

  // The extra top bit of the widened difference is set exactly when the result went negative.
  assign {Bout, D} = {1'b0, A} - {1'b0, B} - {{CHUNK{1'b0}}, Bin};

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: one CHUNK-bit slice per clock through a shared chunk
// subtractor and a registered borrow, wrapped in valid/ready handshakes.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_bits(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("serial_subtractor: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end
  endgenerate

  sub_state_t       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDXW-1:0]  idx;
  logic             borrow;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] diff;
  logic             borrow_next;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready / out_valid come straight from the state register, so neither depends on
  // in_valid or out_ready combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        a_chunk = a_reg[i*CHUNK +: CHUNK];
        b_chunk = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_subtractor #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .A   (a_chunk),
    .B   (b_chunk),
    .Bin (borrow),
    .D   (diff),
    .Bout(borrow_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            borrow <= Bin;
            idx    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) D[i*CHUNK +: CHUNK] <= diff;
          end
          borrow <= borrow_next;
          if (idx == LAST_IDX) begin
            Bout  <= borrow_next;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors on a CHUNK=8 instance, plus
// random traffic on CHUNK=8, CHUNK=1 and CHUNK=64 instances.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] d;
  logic        bout;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_q[$];
  logic        rand_ready  = 1'b0;
  logic        force_ready = 1'b0;
  logic        aux_go      = 1'b0;

  serial_subtractor #(
    .WIDTH(64),
    .CHUNK(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .Bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (d),
    .Bout     (bout)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic bi);
    return {1'b0, x} - {1'b0, y} - {64'd0, bi};
  endfunction

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  // Monitor: the transfer completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected_output: got %h, expected no output", {bout, d});
      end else begin
        check("main_result", {bout, d}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] a_v, input logic [63:0] b_v, input logic bin_v,
                      input logic [64:0] exp, input bit push);
    int budget;
    budget = 0;
    @(posedge clk);
    #1;
    a = a_v;
    b = b_v;
    bin = bin_v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL main_accept_timeout: got in_ready=0, expected 1 within 1000 cycles");
    end else if (push) begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < limit) begin
      @(negedge clk);
      budget++;
    end
    check("main_drain", 65'(exp_q.size()), 65'd0);
  endtask

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : aux
      localparam int C    = (g == 0) ? 1 : 64;
      localparam int NOPS = (g == 0) ? 100 : 500;
      logic        iv;
      logic        ir;
      logic [63:0] aa;
      logic [63:0] bb;
      logic        bi;
      logic        ov;
      logic        orr = 1'b0;
      logic [63:0] dd;
      logic        bo;
      logic        done_flag = 1'b0;
      logic [64:0] aux_q[$];

      serial_subtractor #(
        .WIDTH(64),
        .CHUNK(C)
      ) dut_aux (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (iv),
        .in_ready (ir),
        .A        (aa),
        .B        (bb),
        .Bin      (bi),
        .out_valid(ov),
        .out_ready(orr),
        .D        (dd),
        .Bout     (bo)
      );

      always @(posedge clk) begin
        #2;
        orr = ($urandom_range(0, 3) != 0);
      end

      always @(negedge clk) begin
        if (rst_n && ov && orr) begin
          if (aux_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL aux_chunk%0d_unexpected_output: got %h, expected no output", C, {bo, dd});
          end else begin
            check($sformatf("aux_chunk%0d_result", C), {bo, dd}, aux_q.pop_front());
          end
        end
      end

      initial begin
        int budget;
        iv = 1'b0;
        aa = '0;
        bb = '0;
        bi = 1'b0;
        wait (aux_go);
        for (int n = 0; n < NOPS; n++) begin
          budget = 0;
          @(posedge clk);
          #1;
          aa = {$urandom, $urandom};
          bb = (n % 25 == 0) ? aa : {$urandom, $urandom};
          bi = 1'($urandom_range(0, 1));
          iv = 1'b1;
          @(negedge clk);
          while (!ir && budget < 2000) begin
            @(negedge clk);
            budget++;
          end
          if (!ir) begin
            checks++;
            errors++;
            $display("FAIL aux_chunk%0d_accept_timeout: got in_ready=0, expected 1", C);
          end else begin
            aux_q.push_back(model(aa, bb, bi));
          end
          @(posedge clk);
          #1;
          iv = 1'b0;
        end
        budget = 0;
        while (aux_q.size() != 0 && budget < 5000) begin
          @(negedge clk);
          budget++;
        end
        check($sformatf("aux_chunk%0d_drain", C), 65'(aux_q.size()), 65'd0);
        done_flag = 1'b1;
      end
    end
  endgenerate

  initial begin
    int cnt;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbi;

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    force_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 65'(in_ready), 65'd1);
    check("reset_out_valid", 65'(out_valid), 65'd0);
    check("reset_d", 65'(d), 65'd0);
    check("reset_bout", 65'(bout), 65'd0);
    rst_n = 1'b1;

    // Basic vector with latency measured from the accept edge.
    send(64'd10, 64'd3, 1'b0, {1'b0, 64'd7}, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("basic_latency", 65'(cnt), 65'd8);

    send(64'd0, 64'd1, 1'b0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    send(64'd5, 64'd5, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    send(64'h100, 64'h1, 1'b0, {1'b0, 64'hFF}, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b1);
    send(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, {1'b0, 64'd0}, 1'b1);
    send(64'd0, 64'd0, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, {1'b0, 64'd0}, 1'b1);
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
         {1'b1, 64'hF012_3456_789A_BCDE}, 1'b1);
    wait_drain(200);

    // Backpressure: hold the result while new operands are offered.
    force_ready = 1'b0;
    send(64'h1234, 64'h34, 1'b0, {1'b0, 64'h1200}, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      bin = 1'b1;
      @(negedge clk);
      check("bp_d", 65'(d), 65'h1200);
      check("bp_bout", 65'(bout), 65'd0);
      check("bp_in_ready", 65'(in_ready), 65'd0);
      check("bp_out_valid", 65'(out_valid), 65'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    force_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", 65'(in_ready), 65'd1);
    check("bp_popped", 65'(exp_q.size()), 65'd0);

    // Reset three cycles into an operation.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 65'(out_valid), 65'd0);
    check("midrst_in_ready", 65'(in_ready), 65'd1);
    check("midrst_d", 65'(d), 65'd0);
    check("midrst_bout", 65'(bout), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(64'h100, 64'h1, 1'b0, {1'b0, 64'hFF}, 1'b1);
    wait_drain(200);

    // Random traffic with random output stalls on every instance.
    rand_ready = 1'b1;
    aux_go = 1'b1;
    for (int n = 0; n < 400; n++) begin
      ra = {$urandom, $urandom};
      rb = (n % 50 == 0) ? ra : {$urandom, $urandom};
      rbi = 1'($urandom_range(0, 1));
      send(ra, rb, rbi, model(ra, rb, rbi), 1'b1);
    end
    wait_drain(2000);

    cnt = 0;
    while (!(aux[0].done_flag && aux[1].done_flag) && cnt < 40000) begin
      @(negedge clk);
      cnt++;
    end
    check("aux_complete", 65'(aux[0].done_flag && aux[1].done_flag), 65'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
